// File: rtl/mod_swapchain_pkg.sv
// mod_swapchain_pkg
// Shared types and defaults for the modulation/STM segment swap chain.
//   swapchain_state_t : FSM state encoding used by swapchain_core
//   SWC_IDX_WIDTH     : default sample index / cycle width (32768-entry segment)
//   SWC_REP_WIDTH     : default repetition field width
//   REP_INFINITE      : repetition value meaning "loop forever"
package mod_swapchain_pkg;

    localparam int SWC_IDX_WIDTH = 15;
    localparam int SWC_REP_WIDTH = 16;

    localparam logic [SWC_REP_WIDTH-1:0] REP_INFINITE = 16'hFFFF;

    typedef enum logic [1:0] {
        INFINITE   = 2'd0,
        WAIT_START = 2'd1,
        FINITE     = 2'd2,
        STOPPED    = 2'd3
    } swapchain_state_t;

endpackage

// File: rtl/swapchain_core.sv
// swapchain_core
// Segment-swap state machine shared by the modulation and STM paths:
// wrap detectors for both segments, the pending-request latch and the
// finite-repetition loop counter. The caller owns the index mux/freeze.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   update_i              : one-cycle settings strobe
//   req_seg_i, rep_i      : requested segment and repetition count (loops-1)
//   cycle_0_i, cycle_1_i  : last index of each segment
//   idx_0_i, idx_1_i      : free-running timer indices of each segment
//   loop_cnt_o, busy_o    : status (only with MOD_SWAPCHAIN_STATUS_EN)
//   seg_q_o / seg_d_o     : current segment and its next value
//   stop_q_o              : repetitions exhausted
//   hold_o                : next cycle is in STOPPED (index must freeze)
module swapchain_core
    import mod_swapchain_pkg::*;
#(
    parameter int IDX_WIDTH = SWC_IDX_WIDTH,
    parameter int REP_WIDTH = SWC_REP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 update_i,
    input  logic                 req_seg_i,
    input  logic [REP_WIDTH-1:0] rep_i,
    input  logic [IDX_WIDTH-1:0] cycle_0_i,
    input  logic [IDX_WIDTH-1:0] cycle_1_i,
    input  logic [IDX_WIDTH-1:0] idx_0_i,
    input  logic [IDX_WIDTH-1:0] idx_1_i,
`ifdef MOD_SWAPCHAIN_STATUS_EN
    output logic [REP_WIDTH-1:0] loop_cnt_o,
    output logic                 busy_o,
`endif
    output logic                 seg_q_o,
    output logic                 seg_d_o,
    output logic                 stop_q_o,
    output logic                 hold_o
);

    swapchain_state_t       state_q, state_d;
    logic                   seg_q, seg_d;
    logic                   stop_q, stop_d;
    logic                   req_q, req_d;
    logic [REP_WIDTH-1:0]   rep_q, rep_d;
    logic [REP_WIDTH-1:0]   loop_cnt_q, loop_cnt_d;
    logic [IDX_WIDTH-1:0]   prev_idx_0_q, prev_idx_0_d;
    logic [IDX_WIDTH-1:0]   prev_idx_1_q, prev_idx_1_d;
    logic [1:0]             wrap;
    logic                   accept;

    // A segment wraps when its timer goes from the last index back to 0.
    always_comb begin
        prev_idx_0_d = idx_0_i;
        prev_idx_1_d = idx_1_i;
        wrap[0]      = (prev_idx_0_q == cycle_0_i) && (idx_0_i == '0);
        wrap[1]      = (prev_idx_1_q == cycle_1_i) && (idx_1_i == '0);
    end

    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        stop_d     = stop_q;
        req_d      = req_q;
        rep_d      = rep_q;
        loop_cnt_d = loop_cnt_q;

        // While playing, a request for the segment already on air is a no-op;
        // while waiting or stopped every request is taken as a fresh one.
        accept = update_i && ((state_q == WAIT_START) || (state_q == STOPPED) ||
                              (req_seg_i != seg_q));

        if (accept) begin
            // Update beats a coincident wrap: that wrap is neither a start
            // nor a counted loop.
            stop_d = 1'b0;
            if (rep_i == '1) begin
                seg_d   = req_seg_i;
                state_d = INFINITE;
            end else begin
                req_d   = req_seg_i;
                rep_d   = rep_i;
                state_d = WAIT_START;
            end
        end else begin
            case (state_q)
                WAIT_START: begin
                    if (wrap[req_q]) begin
                        seg_d      = req_q;
                        loop_cnt_d = '0;
                        state_d    = FINITE;
                    end
                end
                FINITE: begin
                    if (wrap[seg_q]) begin
                        if (loop_cnt_q == rep_q) begin
                            state_d = STOPPED;
                            stop_d  = 1'b1;
                        end else begin
                            loop_cnt_d = loop_cnt_q + REP_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INFINITE;
            seg_q        <= 1'b0;
            stop_q       <= 1'b0;
            req_q        <= 1'b0;
            rep_q        <= '1;
            loop_cnt_q   <= '0;
            prev_idx_0_q <= '0;
            prev_idx_1_q <= '0;
        end else begin
            state_q      <= state_d;
            seg_q        <= seg_d;
            stop_q       <= stop_d;
            req_q        <= req_d;
            rep_q        <= rep_d;
            loop_cnt_q   <= loop_cnt_d;
            prev_idx_0_q <= prev_idx_0_d;
            prev_idx_1_q <= prev_idx_1_d;
        end
    end

`ifdef MOD_SWAPCHAIN_STATUS_EN
    logic busy_q, busy_d;

    always_comb busy_d = (state_d == WAIT_START);

    always_ff @(posedge clk) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= busy_d;
    end

    assign loop_cnt_o = loop_cnt_q;
    assign busy_o     = busy_q;
`endif

    assign seg_q_o  = seg_q;
    assign seg_d_o  = seg_d;
    assign stop_q_o = stop_q;
    assign hold_o   = (state_d == STOPPED);

endmodule

// File: rtl/mod_swapchain.sv
// mod_swapchain
// Chooses which modulation segment feeds the sampler and when the swap
// takes effect; freezes the index on the last sample once a finite
// repetition count is exhausted.
// Optional status outputs are built when MOD_SWAPCHAIN_STATUS_EN is defined.
// Ports:
//   CLK, RST             : clock, synchronous active-high reset
//   UPDATE_SETTINGS      : one-cycle strobe, REQ_RD_SEGMENT/REP valid
//   REQ_RD_SEGMENT, REP  : requested segment, loops-1 (all-ones = infinite)
//   CYCLE_0, CYCLE_1     : last index of each segment
//   IDX_0, IDX_1         : free-running timer indices
//   LOOP_CNT, BUSY       : live loop count / waiting for start (status build)
//   SEGMENT, IDX, STOP   : registered segment, BRAM index, exhausted flag
module mod_swapchain
    import mod_swapchain_pkg::*;
#(
    parameter int IDX_WIDTH = SWC_IDX_WIDTH,
    parameter int REP_WIDTH = SWC_REP_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 UPDATE_SETTINGS,
    input  logic                 REQ_RD_SEGMENT,
    input  logic [REP_WIDTH-1:0] REP,
    input  logic [IDX_WIDTH-1:0] CYCLE_0,
    input  logic [IDX_WIDTH-1:0] CYCLE_1,
    input  logic [IDX_WIDTH-1:0] IDX_0,
    input  logic [IDX_WIDTH-1:0] IDX_1,
`ifdef MOD_SWAPCHAIN_STATUS_EN
    output logic [REP_WIDTH-1:0] LOOP_CNT,
    output logic                 BUSY,
`endif
    output logic                 SEGMENT,
    output logic [IDX_WIDTH-1:0] IDX,
    output logic                 STOP
);

    logic                 seg_q, seg_d, stop_q, hold;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;

    swapchain_core #(
        .IDX_WIDTH (IDX_WIDTH),
        .REP_WIDTH (REP_WIDTH)
    ) u_core (
        .clk       (CLK),
        .rst       (RST),
        .update_i  (UPDATE_SETTINGS),
        .req_seg_i (REQ_RD_SEGMENT),
        .rep_i     (REP),
        .cycle_0_i (CYCLE_0),
        .cycle_1_i (CYCLE_1),
        .idx_0_i   (IDX_0),
        .idx_1_i   (IDX_1),
`ifdef MOD_SWAPCHAIN_STATUS_EN
        .loop_cnt_o(LOOP_CNT),
        .busy_o    (BUSY),
`endif
        .seg_q_o   (seg_q),
        .seg_d_o   (seg_d),
        .stop_q_o  (stop_q),
        .hold_o    (hold)
    );

    // Mux on the next segment so a swap shows the new segment's index in the
    // same cycle SEGMENT changes. On entry to STOPPED the timer has already
    // rolled to 0, so the last sample is taken from CYCLE rather than IDX.
    always_comb begin
        if (hold) begin
            if (stop_q) idx_d = idx_q;
            else        idx_d = seg_q ? CYCLE_1 : CYCLE_0;
        end else begin
            idx_d = seg_d ? IDX_1 : IDX_0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) idx_q <= '0;
        else     idx_q <= idx_d;
    end

    assign SEGMENT = seg_q;
    assign IDX     = idx_q;
    assign STOP    = stop_q;

endmodule

// File: tb/tb_mod_swapchain.sv
module tb_mod_swapchain;
    import mod_swapchain_pkg::*;

    localparam logic [14:0] C0  = 15'd5;
    localparam logic [14:0] C1  = 15'd3;
    localparam logic [15:0] INF = REP_INFINITE;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        UPDATE_SETTINGS = 1'b0;
    logic        REQ_RD_SEGMENT = 1'b0;
    logic [15:0] REP = 16'hFFFF;
    logic [14:0] CYCLE_0 = C0;
    logic [14:0] CYCLE_1 = C1;
    logic [14:0] IDX_0 = '0;
    logic [14:0] IDX_1 = '0;
    logic        SEGMENT;
    logic [14:0] IDX;
    logic        STOP;
`ifdef MOD_SWAPCHAIN_STATUS_EN
    logic [15:0] LOOP_CNT;
    logic        BUSY;
`endif

    mod_swapchain dut (
        .CLK            (CLK),
        .RST            (RST),
        .UPDATE_SETTINGS(UPDATE_SETTINGS),
        .REQ_RD_SEGMENT (REQ_RD_SEGMENT),
        .REP            (REP),
        .CYCLE_0        (CYCLE_0),
        .CYCLE_1        (CYCLE_1),
        .IDX_0          (IDX_0),
        .IDX_1          (IDX_1),
`ifdef MOD_SWAPCHAIN_STATUS_EN
        .LOOP_CNT       (LOOP_CNT),
        .BUSY           (BUSY),
`endif
        .SEGMENT        (SEGMENT),
        .IDX            (IDX),
        .STOP           (STOP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        seg;
        logic        stop;
        logic [14:0] idx;
        int          id;
        bit          chk_st;
        logic [15:0] loop;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          nstep  = 0;
    logic [14:0] t0 = '0;
    logic [14:0] t1 = '0;
    bit          st_chk = 1'b0;
    logic [15:0] st_loop = '0;
    logic        st_busy = 1'b0;

    // Status expectation attached to the next step only.
    task automatic set_st(input logic [15:0] l, input logic b);
        st_chk  = 1'b1;
        st_loop = l;
        st_busy = b;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    // Expected IDX is the timer value of the expected segment unless frozen.
    task automatic step(input bit rst, input bit upd, input bit req, input logic [15:0] rep,
                        input bit eseg, input bit estop, input bit efrz, input logic [14:0] fval);
        exp_t e;
        @(negedge CLK);
        RST             = rst;
        UPDATE_SETTINGS = upd;
        REQ_RD_SEGMENT  = req;
        REP             = rep;
        IDX_0           = t0;
        IDX_1           = t1;
        e.seg    = eseg;
        e.stop   = estop;
        e.idx    = efrz ? fval : (eseg ? t1 : t0);
        e.id     = nstep;
        e.chk_st = st_chk;
        e.loop   = st_loop;
        e.busy   = st_busy;
        exp_q.push_back(e);
        st_chk = 1'b0;
        nstep++;
        t0 = (t0 == C0) ? 15'd0 : t0 + 15'd1;
        t1 = (t1 == C1) ? 15'd0 : t1 + 15'd1;
    endtask

    task automatic run(input int n, input bit eseg, input bit estop);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, INF, eseg, estop, 1'b0, '0);
    endtask

    task automatic frozen(input int n, input bit eseg, input logic [14:0] v);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, INF, eseg, 1'b1, 1'b1, v);
    endtask

    // Monitor: outputs are valid every cycle, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (SEGMENT !== e.seg || IDX !== e.idx || STOP !== e.stop) begin
                    errors++;
                    $display("FAIL outputs@step%0d: got seg=%0d idx=%0d stop=%0d, want seg=%0d idx=%0d stop=%0d",
                             e.id, SEGMENT, IDX, STOP, e.seg, e.idx, e.stop);
                end
`ifdef MOD_SWAPCHAIN_STATUS_EN
                if (e.chk_st) begin
                    checks++;
                    if (LOOP_CNT !== e.loop || BUSY !== e.busy) begin
                        errors++;
                        $display("FAIL status@step%0d: got loop=%0d busy=%0d, want loop=%0d busy=%0d",
                                 e.id, LOOP_CNT, BUSY, e.loop, e.busy);
                    end
                end
`endif
            end
        end
    end

    initial begin
        // Reset: segment 0, index 0, not stopped.
        set_st(16'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, INF, 1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b0, INF, 1'b0, 1'b0, 1'b1, '0);
        run(8, 1'b0, 1'b0);                                  // tracks IDX_0, wraps ignored

        // Infinite switch to seg1 takes effect on the next edge.
        step(1'b0, 1'b1, 1'b1, INF, 1'b1, 1'b0, 1'b0, '0);
        run(6, 1'b1, 1'b0);
        // Same-segment request while infinite is ignored.
        step(1'b0, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, INF, 1'b0, 1'b0, 1'b0, '0);   // back to seg0
        run(3, 1'b0, 1'b0);

        // Finite REP=1 on seg1 requested while IDX_1 is 2.
        t1 = 15'd2;
        set_st(16'd0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, '0); // WAIT_START, still seg0
        run(1, 1'b0, 1'b0);                                  // IDX_1 = 3
        run(8, 1'b1, 1'b0);                                  // swap on 3->0, two plays
        step(1'b0, 1'b0, 1'b0, INF, 1'b1, 1'b1, 1'b1, C1);   // third wrap: stop at 3
        frozen(4, 1'b1, C1);

        // STOPPED, finite REP=0 on same segment: wait for wrap, play once.
        step(1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, '0);
        run(6, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, INF, 1'b1, 1'b1, 1'b1, C1);
        frozen(2, 1'b1, C1);

        // STOPPED, infinite request to seg0 switches at once.
        step(1'b0, 1'b1, 1'b0, INF, 1'b0, 1'b0, 1'b0, '0);
        run(1, 1'b0, 1'b0);
        // WAIT_START cancelled by an infinite request back to seg0.
        t1 = 15'd1;
        set_st(16'd0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, '0);
        set_st(16'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, INF, 1'b0, 1'b0, 1'b0, '0);
        run(6, 1'b0, 1'b0);                                  // seg1 wraps, no swap

        // Update coinciding with the awaited wrap: the wrap is not taken.
        t1 = 15'd2;
        step(1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, '0);
        run(1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, '0); // IDX_1 = 0 here
        run(3, 1'b0, 1'b0);
        run(4, 1'b1, 1'b0);                                  // next wrap starts it
        step(1'b0, 1'b0, 1'b0, INF, 1'b1, 1'b1, 1'b1, C1);
        frozen(1, 1'b1, C1);

        // Reset in FINITE with loop_cnt = 5.
        t1 = 15'd1;
        step(1'b0, 1'b1, 1'b1, 16'd10, 1'b1, 1'b0, 1'b0, '0);
        run(2, 1'b1, 1'b0);
        run(20, 1'b1, 1'b0);
        set_st(16'd5, 1'b0);
        run(1, 1'b1, 1'b0);
        set_st(16'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, INF, 1'b0, 1'b0, 1'b1, '0);
        run(3, 1'b0, 1'b0);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
